elastic_pipeline: RTL and testbench

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/pipe_slice.sv | 90 +++++++++
 rtl/elastic_pipeline.sv | 66 ++++++
 tb/tb_elastic_pipeline.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the elastic register-slice pipeline.
// Holds the slice state encoding and the occupancy width function.
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    MAIN,
    MAIN_SKID
  } slice_st_e;

  function automatic int cnt_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One elastic stage: main register plus skid register.
// Upstream ready comes straight from a flop, never from out_ready.
module pipe_slice
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
);

  slice_st_e        st_q, st_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q;
  logic             acc, drn;

  assign acc = in_valid & rdy_q;
  assign drn = (st_q != EMPTY) & out_ready;

  always_comb begin
    st_d   = st_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush_in) begin
      st_d   = EMPTY;
      main_d = '0;
      skid_d = '0;
    end else begin
      unique case (st_q)
        EMPTY: begin
          if (acc) begin
            st_d   = MAIN;
            main_d = data_in;
          end
        end
        MAIN: begin
          if (acc && drn) begin
            main_d = data_in;
          end else if (acc) begin
            st_d   = MAIN_SKID;
            skid_d = data_in;
          end else if (drn) begin
            st_d   = EMPTY;
            main_d = '0;
          end
        end
        MAIN_SKID: begin
          // main drains first, skid moves up behind it
          if (drn) begin
            st_d   = MAIN;
            main_d = skid_q;
            skid_d = '0;
          end
        end
        default: begin
          st_d   = EMPTY;
          main_d = '0;
          skid_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      st_q   <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q  <= (st_d != MAIN_SKID);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (st_q != EMPTY);
  assign data_out  = main_q;

endmodule

// File: rtl/elastic_pipeline.sv
// Chain of STAGES elastic slices with an occupancy counter.
// Words leave in acceptance order after STAGES cycles when unstalled.
module elastic_pipeline
  import pipeline_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int STAGES = 2,
  localparam int CNT_W  = cnt_w(STAGES)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] count_out
);

  logic             vld [STAGES+1];
  logic             rdy [STAGES+1];
  logic [WIDTH-1:0] dat [STAGES+1];
  logic             xin, xout;

  assign vld[0]      = in_valid;
  assign dat[0]      = data_in;
  assign rdy[STAGES] = out_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    pipe_slice #(
      .WIDTH(WIDTH)
    ) u_slice (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .flush_in (flush_in),
      .in_valid (vld[g]),
      .in_ready (rdy[g]),
      .data_in  (dat[g]),
      .out_valid(vld[g+1]),
      .out_ready(rdy[g+1]),
      .data_out (dat[g+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES];
  assign data_out  = dat[STAGES];

  assign xin  = in_valid & rdy[0];
  assign xout = vld[STAGES] & out_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_out <= '0;
    end else if (flush_in) begin
      count_out <= '0;
    end else if (xin && !xout) begin
      count_out <= count_out + CNT_W'(1);
    end else if (!xin && xout) begin
      count_out <= count_out - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: vector table, hand sequences,
// and random backpressure against a queue reference model.
module tb_elastic_pipeline;

  logic        clk;
  logic        rst;
  logic        fl, iv, ordy;
  logic [15:0] din;
  logic        ir, ov;
  logic [15:0] dout;
  logic [2:0]  cnt;

  logic        fl3, iv3, ordy3;
  logic [15:0] din3;
  logic        ir3, ov3;
  logic [15:0] dout3;
  logic [2:0]  cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  elastic_pipeline #(.WIDTH(16), .STAGES(2)) u_dut (
    .clk_in(clk), .rst_in(rst), .flush_in(fl),
    .in_valid(iv), .in_ready(ir), .data_in(din),
    .out_valid(ov), .out_ready(ordy), .data_out(dout),
    .count_out(cnt)
  );

  elastic_pipeline #(.WIDTH(16), .STAGES(3)) u_dut3 (
    .clk_in(clk), .rst_in(rst), .flush_in(fl3),
    .in_valid(iv3), .in_ready(ir3), .data_in(din3),
    .out_valid(ov3), .out_ready(ordy3), .data_out(dout3),
    .count_out(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_do;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_all();
    iv = 0; ordy = 0; fl = 1;
    tick();
    fl = 0;
  endtask

  initial begin
    int sent, got, cyc, cm;
    logic [15:0] q[$];
    logic        pstall;
    logic [15:0] pdo;
    logic        xi, xo;

    rst = 1; fl = 0; iv = 0; ordy = 0; din = 0;
    fl3 = 0; iv3 = 0; ordy3 = 0; din3 = 0;

    tv[0] = '{1'b1, 16'hA001, 1'b0, 1'b1, 1'b0, 16'h0,    3'd0};
    tv[1] = '{1'b1, 16'hA002, 1'b0, 1'b1, 1'b0, 16'h0,    3'd1};
    tv[2] = '{1'b1, 16'hA003, 1'b0, 1'b1, 1'b1, 16'hA001, 3'd2};
    tv[3] = '{1'b1, 16'hA004, 1'b0, 1'b1, 1'b1, 16'hA001, 3'd3};
    tv[4] = '{1'b1, 16'hA005, 1'b0, 1'b0, 1'b1, 16'hA001, 3'd4};
    tv[5] = '{1'b1, 16'hA005, 1'b1, 1'b0, 1'b1, 16'hA001, 3'd4};
    tv[6] = '{1'b0, 16'h0,    1'b1, 1'b0, 1'b1, 16'hA002, 3'd3};
    tv[7] = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'hA003, 3'd2};
    tv[8] = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'hA004, 3'd1};
    tv[9] = '{1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 16'h0,    3'd0};

    #12;
    chk("rst_ov", ov, 0);
    chk("rst_do", dout, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ir", ir, 0);
    #10 rst = 0;
    tick();
    chk("rel_ir", ir, 1);
    chk("rel_ir3", ir3, 1);

    // stall/fill then drain
    for (int i = 0; i < 10; i++) begin
      iv = tv[i].iv; din = tv[i].d; ordy = tv[i].ordy;
      @(negedge clk);
      chk($sformatf("tv%0d_ir", i), ir, tv[i].e_ir);
      chk($sformatf("tv%0d_ov", i), ov, tv[i].e_ov);
      chk($sformatf("tv%0d_do", i), dout, tv[i].e_do);
      chk($sformatf("tv%0d_cnt", i), cnt, tv[i].e_cnt);
      tick();
    end

    // latency, three stages
    iv3 = 1; din3 = 16'h1234; ordy3 = 1;
    tick();
    iv3 = 0; din3 = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat%0d_ov", k), ov3, (k == 3) ? 1 : 0);
      chk($sformatf("lat%0d_do", k), dout3,
          (k == 3) ? 16'h1234 : 16'h0);
      chk($sformatf("lat%0d_cnt", k), cnt3, (k == 4) ? 0 : 1);
      tick();
    end

    // streaming
    sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 400) begin
      iv = (sent < 100); din = 16'(sent + 1); ordy = 1;
      @(negedge clk);
      if (sent < 100) chk("str_ir", ir, 1);
      if (sent < 100 && cyc >= 2) chk("str_cnt", cnt, 2);
      if (ov) begin
        chk("str_do", dout, 16'(got + 1));
        got++;
      end
      if (iv && ir) sent++;
      tick();
      cyc++;
    end
    chk("str_got", got, 100);
    iv = 0;

    // flush with three words held and a word offered
    ordy = 0;
    for (int k = 0; k < 3; k++) begin
      iv = 1; din = 16'hB000 + 16'(k);
      tick();
    end
    chk("fl_pre_cnt", cnt, 3);
    iv = 1; din = 16'hDEAD; fl = 1;
    tick();
    fl = 0; iv = 0; ordy = 1;
    chk("fl_cnt", cnt, 0);
    chk("fl_ov", ov, 0);
    chk("fl_do", dout, 0);
    chk("fl_ir", ir, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fl_quiet", ov, 0);
      tick();
    end

    // random backpressure vs queue model
    sent = 0; got = 0; cyc = 0; cm = 0;
    pstall = 0; pdo = 0;
    while (got < 1000 && cyc < 20000) begin
      iv = (sent < 1000) && ($urandom_range(1) == 1);
      din = 16'($urandom);
      ordy = ($urandom_range(1) == 1);
      @(negedge clk);
      chk("rnd_cnt", cnt, cm);
      if (ir) chk("rnd_room", cm < 4, 1);
      if (q.size() == 0) begin
        chk("rnd_empty_ov", ov, 0);
        chk("rnd_empty_do", dout, 0);
      end
      if (ov && q.size() > 0) chk("rnd_do", dout, q[0]);
      if (!ov) chk("rnd_zero_do", dout, 0);
      if (pstall) begin
        chk("rnd_hold_ov", ov, 1);
        chk("rnd_hold_do", dout, pdo);
      end
      xi = iv && ir;
      xo = ov && ordy;
      if (xo) begin
        if (q.size() > 0) void'(q.pop_front());
        got++;
        cm--;
      end
      if (xi) begin
        q.push_back(din);
        sent++;
        cm++;
      end
      pstall = ov && !ordy;
      pdo = dout;
      tick();
      cyc++;
    end
    chk("rnd_got", got, 1000);
    iv = 0;
    flush_all();

    // async reset with two words held
    ordy = 0;
    for (int k = 0; k < 2; k++) begin
      iv = 1; din = 16'hC000 + 16'(k);
      tick();
    end
    iv = 0;
    chk("ar_pre_cnt", cnt, 2);
    #2 rst = 1;
    #1;
    chk("ar_ov", ov, 0);
    chk("ar_do", dout, 0);
    chk("ar_cnt", cnt, 0);
    chk("ar_ir", ir, 0);
    #3 rst = 0;
    tick();
    chk("ar_rel_ir", ir, 1);
    chk("ar_rel_ov", ov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
